// File: rtl/mole_render_pkg.sv
// Shared constants for the whack-a-mole field renderer: palette, cell geometry
// and the visible-frame boundary.
package mole_render_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t GRASS = 12'h292;
    localparam rgb_t HOLE  = 12'h321;
    localparam rgb_t MOLE  = 12'h952;
    localparam rgb_t FLASH = 12'hFFF;
    localparam rgb_t BLACK = 12'h000;

    localparam int          CELL_SIZE  = 256;
    localparam int          GRID_CELLS = 3;
    localparam logic [10:0] GRID_SPAN  = 11'(CELL_SIZE * GRID_CELLS);

    localparam logic [7:0] HOLE_LO   = 8'd32;
    localparam logic [7:0] HOLE_HI   = 8'd223;
    localparam logic [7:0] MOLE_X_LO = 8'd64;
    localparam logic [7:0] MOLE_X_HI = 8'd191;
    localparam logic [7:0] MOLE_Y_LO = 8'd48;
    localparam logic [7:0] MOLE_Y_HI = 8'd223;

    localparam logic [9:0] LAST_LINE = 10'd799;

    function automatic logic in_span(input logic [7:0] v, input logic [7:0] lo,
                                     input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/mole_field_renderer_if.sv
// Pixel-source bus between the VGA timing stage / game logic and the renderer.
interface mole_field_renderer_if;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic [8:0]  mole_up;
    logic [8:0]  hit;
    logic [3:0]  r_in;
    logic [3:0]  g_in;
    logic [3:0]  b_in;
    logic        frame_tick;

    modport master (output curr_x, curr_y, mole_up, hit,
                    input  r_in, g_in, b_in, frame_tick);
    modport slave  (input  curr_x, curr_y, mole_up, hit,
                    output r_in, g_in, b_in, frame_tick);
endinterface

// File: rtl/mole_flash_timer.sv
// Per-hole flash lifetime: reload on hit, count down one per frame, park at 0.
module mole_flash_timer #(
    parameter int FLASH_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       frame_tick,
    output logic [5:0] cnt
);
    localparam logic [5:0] LOAD = 6'(FLASH_FRAMES);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (hit)
            cnt <= LOAD;
        else if (frame_tick && cnt != '0)
            cnt <= cnt - 6'd1;
    end
endmodule

// File: rtl/mole_field_renderer.sv
// 3x3 whack-a-mole picture generator; game state is sampled once per frame so
// the image never tears, colour is registered one cycle after the coordinate.
module mole_field_renderer
    import mole_render_pkg::*;
#(
    parameter int FLASH_FRAMES = 30,
    parameter int GRID_X0      = 256,
    parameter int GRID_Y0      = 16
) (
    input logic                  clk,
    input logic                  rst,
    mole_field_renderer_if.slave bus
);
    localparam int          NUM_HOLES = 9;
    localparam logic [10:0] X0 = 11'(GRID_X0);
    localparam logic [10:0] Y0 = 11'(GRID_Y0);

    logic [9:0]                  prev_y;
    logic                        tick;
    logic [NUM_HOLES-1:0]        mole_sh, flash_sh, flash_on;
    logic [NUM_HOLES-1:0][5:0]   flash_cnt;

    // Same-edge tick drives the shadows and timers; frame_tick is its registered copy.
    assign tick = (prev_y == LAST_LINE) && (bus.curr_y != LAST_LINE);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_y         <= '0;
            bus.frame_tick <= 1'b0;
            mole_sh        <= '0;
            flash_sh       <= '0;
        end else begin
            prev_y         <= bus.curr_y;
            bus.frame_tick <= tick;
            if (tick) begin
                mole_sh  <= bus.mole_up;
                flash_sh <= flash_on;
            end
        end
    end

    for (genvar g = 0; g < NUM_HOLES; g++) begin : g_hole
        mole_flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_tmr (
            .clk        (clk),
            .rst        (rst),
            .hit        (bus.hit[g]),
            .frame_tick (tick),
            .cnt        (flash_cnt[g])
        );
        assign flash_on[g] = |flash_cnt[g];
    end

    logic [10:0] cy, dx, dy;
    logic [1:0]  col, row;
    logic [3:0]  idx;
    logic [7:0]  lx, ly;
    logic        in_grid, in_hole, in_mole;
    rgb_t        pix;

    assign cy  = {1'b0, bus.curr_y};
    assign dx  = bus.curr_x - X0;
    assign dy  = cy - Y0;
    assign col = dx[9:8];
    assign row = dy[9:8];
    assign lx  = dx[7:0];
    assign ly  = dy[7:0];
    assign idx = {2'b00, row} * 4'd3 + {2'b00, col};

    assign in_grid = (bus.curr_x >= X0) && (cy >= Y0) && (dx < GRID_SPAN) && (dy < GRID_SPAN);
    assign in_hole = in_span(lx, HOLE_LO, HOLE_HI) && in_span(ly, HOLE_LO, HOLE_HI);
    assign in_mole = in_span(lx, MOLE_X_LO, MOLE_X_HI) && in_span(ly, MOLE_Y_LO, MOLE_Y_HI);

    always_comb begin
        pix = GRASS;
        if (in_grid && in_hole) begin
            if (flash_sh[idx])
                pix = FLASH;
            else if (mole_sh[idx] && in_mole)
                pix = MOLE;
            else
                pix = HOLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            {bus.r_in, bus.g_in, bus.b_in} <= BLACK;
        else
            {bus.r_in, bus.g_in, bus.b_in} <= pix;
    end
endmodule

// File: tb/tb_mole_field_renderer.sv
// Directed checks of the mole field renderer: palette/geometry table, frame
// latching, flash lifetime/retrigger/collision and mid-frame reset.
module tb_mole_field_renderer;
    import mole_render_pkg::*;

    localparam int FF = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mole_field_renderer_if bus();

    mole_field_renderer #(.FLASH_FRAMES(FF), .GRID_X0(256), .GRID_Y0(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       nm;
        int          x;
        int          y;
        logic [11:0] exp;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(input string n, input int x, input int y, input logic [11:0] e);
        vec_t v;
        v.nm = n; v.x = x; v.y = y; v.exp = e;
        return v;
    endfunction

    function automatic logic [11:0] rgb();
        return {bus.r_in, bus.g_in, bus.b_in};
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int x, input int y);
        @(negedge clk);
        bus.curr_x = 11'(x);
        bus.curr_y = 10'(y);
    endtask

    task automatic chk_pix(input string nm, input int x, input int y, input logic [11:0] exp);
        drive(x, y);
        @(posedge clk); #1;
        chk(nm, rgb(), exp);
    endtask

    // Output must still show the previous pixel until the next edge.
    task automatic chk_lat(input string nm, input int x, input int y,
                           input logic [11:0] exp, input logic [11:0] prev);
        drive(x, y);
        chk({nm, "_pre"}, rgb(), prev);
        @(posedge clk); #1;
        chk(nm, rgb(), exp);
    endtask

    task automatic pulse_hit(input logic [8:0] hv);
        @(negedge clk); bus.hit = hv;
        @(negedge clk); bus.hit = '0;
    endtask

    // End-of-frame: two cycles on line 799 then blanking; hv rides the tick cycle.
    task automatic do_tick(input logic [8:0] hv);
        int n;
        n = 0;
        @(negedge clk); bus.curr_x = '0; bus.curr_y = 10'd799;
        repeat (2) begin @(posedge clk); #1; n += int'(bus.frame_tick); end
        @(negedge clk); bus.curr_y = '0; bus.hit = hv;
        @(posedge clk); #1; n += int'(bus.frame_tick);
        @(negedge clk); bus.hit = '0;
        repeat (2) begin @(posedge clk); #1; n += int'(bus.frame_tick); end
        chk("frame_tick_once", 12'(n), 12'd1);
    endtask

    task automatic flash_frames(input string nm, input int nw);
        for (int i = 0; i < nw; i++) begin
            do_tick('0);
            chk_pix($sformatf("%s_white%0d", nm, i), 868, 628, FLASH);
        end
        do_tick('0);
        chk_pix({nm, "_end"}, 868, 628, HOLE);
    endtask

    initial begin
        int ex[4];
        bus.curr_x = '0; bus.curr_y = '0; bus.mole_up = '0; bus.hit = '0;

        // reset / idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_black", rgb(), BLACK);
        chk("rst_tick", 12'(bus.frame_tick), 12'd0);
        drive(356, 116);
        @(posedge clk); #1;
        chk("rst_black_hole", rgb(), BLACK);
        @(negedge clk); rst = 1'b0;
        chk_pix("idle_origin", 0, 0, GRASS);
        chk_pix("idle_hole0", 356, 116, HOLE);
        chk("idle_no_tick", 12'(bus.frame_tick), 12'd0);

        // mole draw: hole 4 latched by a tick
        bus.mole_up = 9'b000010000;
        chk_pix("mole_unlatched", 612, 372, HOLE);
        do_tick('0);

        tv.push_back(mk("origin",     0,    0,   GRASS));
        tv.push_back(mk("h0_centre",  356,  116, HOLE));
        tv.push_back(mk("h4_centre",  612,  372, MOLE));
        tv.push_back(mk("h4_rim",     552,  312, HOLE));
        tv.push_back(mk("h0_right",   388,  116, HOLE));
        tv.push_back(mk("h8_centre",  868,  628, HOLE));
        tv.push_back(mk("above_grid", 612,  15,  GRASS));
        tv.push_back(mk("below_grid", 612,  784, GRASS));
        tv.push_back(mk("mole_lx63",  575,  372, HOLE));
        tv.push_back(mk("mole_lx64",  576,  372, MOLE));
        tv.push_back(mk("mole_lx191", 703,  372, MOLE));
        tv.push_back(mk("mole_lx192", 704,  372, HOLE));
        tv.push_back(mk("mole_ly47",  612,  319, HOLE));
        tv.push_back(mk("mole_ly48",  612,  320, MOLE));
        tv.push_back(mk("mole_ly223", 612,  495, MOLE));
        tv.push_back(mk("hole_ly224", 612,  496, GRASS));
        tv.push_back(mk("hole_lx31",  543,  372, GRASS));
        tv.push_back(mk("hole_lx224", 736,  372, GRASS));
        foreach (tv[i]) chk_pix(tv[i].nm, tv[i].x, tv[i].y, tv[i].exp);

        // grid edges with latency, each preceded by a hole pixel
        ex = '{255, 256, 1023, 1024};
        foreach (ex[i]) begin
            chk_pix($sformatf("edge_prep%0d", i), 356, 116, HOLE);
            chk_lat($sformatf("edge_x%0d", ex[i]), ex[i], 116, GRASS, HOLE);
        end

        // frame latching: mole 0 raised mid-frame
        chk_pix("mid_frame_h4", 612, 400, MOLE);
        bus.mole_up[0] = 1'b1;
        chk_pix("h0_before_tick", 356, 116, HOLE);
        do_tick('0);
        chk_pix("h0_after_tick", 356, 116, MOLE);

        // flash lifetime
        bus.mole_up = '0;
        do_tick('0);
        pulse_hit(9'h100);
        chk_pix("flash_pre_tick", 868, 628, HOLE);
        flash_frames("life", FF);

        // hit coinciding with tick while count is 1
        pulse_hit(9'h100);
        do_tick('0);
        do_tick('0);
        do_tick(9'h100);
        chk_pix("coll_white", 868, 628, FLASH);
        flash_frames("coll", FF);

        // second hit mid-flash restarts the count
        pulse_hit(9'h100);
        do_tick('0);
        pulse_hit(9'h100);
        flash_frames("retrig", FF);

        // mid-frame reset clears shadows and timers
        bus.mole_up = 9'b000010000;
        pulse_hit(9'h100);
        do_tick('0);
        chk_pix("pre_rst_h4", 612, 372, MOLE);
        chk_pix("pre_rst_h8", 868, 628, FLASH);
        drive(612, 372);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_black", rgb(), BLACK);
        @(negedge clk); rst = 1'b0;
        chk_pix("post_rst_h4", 612, 372, HOLE);
        chk("post_rst_tick", 12'(bus.frame_tick), 12'd0);
        chk_pix("post_rst_h8", 868, 628, HOLE);
        bus.mole_up = '0;
        do_tick('0);
        chk_pix("post_rst_cnt_clear", 868, 628, HOLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
